// File: rtl/hs_elastic_fifo_pkg.sv
// Shared definitions for the hs_elastic_fifo req/ack elastic buffer:
// handshake state encoding, default payload width and level-width helper.
package hs_pkg;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_REQ  = 1'b1
  } hs_state_e;

  localparam int DATA_WIDTH_DEF = 32;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int LEVEL_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_elastic_fifo_if.sv
// Req/ack bundle between the elastic FIFO, its upstream producer and its
// downstream consumer; slave is the FIFO's view, master the environment's.
interface hs_elastic_fifo_if #(
  parameter int data_width = hs_pkg::DATA_WIDTH_DEF,
  parameter int depth      = 4
) ();

  logic                                req_l;
  logic                                ack_l;
  logic [data_width-1:0]               din;
  logic                                req_r;
  logic                                ack_r;
  logic [data_width-1:0]               dout;
  logic [hs_pkg::LEVEL_W(depth)-1:0]   level;

  modport slave (
    output req_l, ack_r, dout, level,
    input  ack_l, din, req_r
  );

  modport master (
    input  req_l, ack_r, dout, level,
    output ack_l, din, req_r
  );

endinterface

// File: rtl/hs_elastic_fifo_mem.sv
// hs_fifo_mem: depth x data_width register array with a synchronous write
// port and a registered synchronous read port.
module hs_fifo_mem #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [data_width-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [data_width-1:0]    rdata
);

  logic [data_width-1:0] mem_q [depth];
  logic [data_width-1:0] rdata_q;

  // NOTE: the storage array is deliberately not reset; stale entries are
  // unreachable once the pointers are cleared, and only rdata needs a value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // rdata doubles as the downstream dout: it holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hs_elastic_fifo.sv
// Elastic req/ack buffer: requester toward upstream, responder toward
// downstream. Optional statistics enabled by HS_ELASTIC_FIFO_STATS_EN.
module hs_elastic_fifo
  import hs_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int depth      = 4,
  parameter int fifo_id    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  hs_elastic_fifo_if.slave            bus
`ifdef HS_ELASTIC_FIFO_STATS_EN
  ,
  output logic [LEVEL_W(depth)-1:0]   max_level,
  output logic [31:0]                 stall_cycles,
  output logic                        proto_err
`endif
);

  localparam int PTR_W = $clog2(depth);
  localparam int LVL_W = LEVEL_W(depth);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(depth);

  hs_state_e          up_state_q, up_state_d;
  logic               ack_r_q, ack_r_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               wr_en, rd_en;
  logic               mem_we;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    up_state_d = up_state_q;
    wr_en      = (up_state_q == HS_REQ) && bus.ack_l;
    // A read looks only at the registered level: a same-cycle write into an
    // empty buffer cannot be forwarded, which keeps din off the dout path.
    rd_en      = bus.req_r && !ack_r_q && (level_q != '0);

    case (up_state_q)
      HS_IDLE: if (!bus.ack_l && (level_q < DEPTH_LVL)) up_state_d = HS_REQ;
      HS_REQ:  if (bus.ack_l) up_state_d = HS_IDLE;
      default: up_state_d = HS_IDLE;
    endcase

    ack_r_d = rd_en;
    wptr_d  = wptr_q + PTR_W'(wr_en);
    rptr_d  = rptr_q + PTR_W'(rd_en);
    level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_state_q <= HS_IDLE;
      ack_r_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
    end else begin
      up_state_q <= up_state_d;
      ack_r_q    <= ack_r_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
    end
  end

  assign mem_we = wr_en && !rst;

  hs_fifo_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (bus.din),
    .re    (rd_en),
    .raddr (rptr_q),
    .rdata (bus.dout)
  );

  assign bus.req_l = (up_state_q == HS_REQ);
  assign bus.ack_r = ack_r_q;
  assign bus.level = level_q;

`ifdef HS_ELASTIC_FIFO_STATS_EN
  logic [LVL_W-1:0] max_level_q;
  logic [31:0]      stall_q;
  logic             proto_err_q;
  logic             stall_now, proto_now;

  assign stall_now = bus.req_r && (level_q == '0) && !ack_r_q;
  assign proto_now = bus.ack_l && (up_state_q != HS_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      max_level_q <= '0;
      stall_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (level_d > max_level_q) max_level_q <= level_d;
      if (stall_now) stall_q <= stall_q + 32'd1;
      if (proto_now) proto_err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && proto_now && !proto_err_q) begin
      $display("hs_elastic_fifo %0d: proto_err=1 (ack_l without req_l)", fifo_id);
    end
  end
`endif

  assign max_level    = max_level_q;
  assign stall_cycles = stall_q;
  assign proto_err    = proto_err_q;
`endif

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Randomized scoreboard bench for hs_elastic_fifo; statistics outputs are
// checked when HS_ELASTIC_FIFO_STATS_EN is defined.
module tb_hs_elastic_fifo;
  import hs_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = LEVEL_W(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hs_elastic_fifo_if #(.data_width(DW), .depth(DEPTH)) bus ();

`ifdef HS_ELASTIC_FIFO_STATS_EN
  logic [LW-1:0] max_level;
  logic [31:0]   stall_cycles;
  logic          proto_err;
`endif

  hs_elastic_fifo #(
    .data_width (DW),
    .depth      (DEPTH),
    .fifo_id    (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave)
`ifdef HS_ELASTIC_FIFO_STATS_EN
    ,
    .max_level    (max_level),
    .stall_cycles (stall_cycles),
    .proto_err    (proto_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] next_word = '0;
  logic [DW-1:0] last_dout = '0;
  logic [DW-1:0] first_pop = '0;
  int pushed = 0;
  int popped = 0;
  int max_seen = 0;
  bit prev_ack = 1'b0;
  bit capture_first = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge, pops and compares.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_dout = '0;
      prev_ack  = 1'b0;
    end
    if (bus.ack_r) begin
      check("ack_not_back_to_back", 64'(prev_ack), 64'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack_r=1 dout=0x%0h expected no ack (model empty)", bus.dout);
      end else begin
        logic [DW-1:0] exp_w;
        exp_w = q.pop_front();
        check("dout_order", 64'(bus.dout), 64'(exp_w));
        popped++;
        last_dout = exp_w;
        if (capture_first) begin
          first_pop     = bus.dout;
          capture_first = 1'b0;
        end
      end
    end else begin
      check("dout_hold", 64'(bus.dout), 64'(last_dout));
    end
    prev_ack = bus.ack_r;
    check("level_vs_model", 64'(bus.level), 64'(q.size()));
    if (int'(bus.level) == DEPTH) check("full_no_req", 64'(bus.req_l), 64'd0);
    if (int'(bus.level) > max_seen) max_seen = int'(bus.level);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expired expected $finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of producer/consumer behaviour; fail rates in percent.
  task automatic drive_now(input int up_fail, input int dn_fail, input bit prod_en, input bit cons_en);
    if (prod_en && bus.req_l && (int'($urandom_range(99)) >= up_fail)) begin
      bus.ack_l = 1'b1;
      bus.din   = next_word;
      q.push_back(next_word);
      next_word++;
      pushed++;
    end else begin
      bus.ack_l = 1'b0;
    end
    bus.req_r = cons_en && (int'($urandom_range(99)) >= dn_fail);
  endtask

  task automatic cycle(input int up_fail, input int dn_fail, input bit prod_en, input bit cons_en);
    @(negedge clk);
    drive_now(up_fail, dn_fail, prod_en, cons_en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.ack_l = 1'b0;
    bus.req_r = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0, push0;
    bit found;
    logic [DW-1:0] fresh;

    bus.ack_l = 1'b0;
    bus.din   = '0;
    bus.req_r = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_l", 64'(bus.req_l), 64'd0);
    check("rst_ack_r", 64'(bus.ack_r), 64'd0);
    check("rst_dout",  64'(bus.dout),  64'd0);
    check("rst_level", 64'(bus.level), 64'd0);
`ifdef HS_ELASTIC_FIFO_STATS_EN
    check("rst_max_level", 64'(max_level), 64'd0);
    check("rst_stall",     64'(stall_cycles), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
`endif
    rst = 1'b0;

    // Streaming at full rate on both sides.
    next_word = '0; pushed = 0; popped = 0; max_seen = 0;
    for (int i = 0; i < 12000 && popped < 5000; i++) cycle(0, 0, pushed < 5000, 1'b1);
    check("stream_words", 64'(popped), 64'd5000);
    check("stream_level_le2", 64'(max_seen <= 2), 64'd1);
    for (int i = 0; i < 50 && q.size() != 0; i++) cycle(0, 0, 1'b0, 1'b1);
    repeat (2) cycle(0, 0, 1'b0, 1'b0);
    check("stream_drained", 64'(q.size()), 64'd0);

    // Downstream stalled: fill to depth, probe protocol error, then drain.
    do_reset();
    next_word = '0;
    repeat (20) cycle(0, 0, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_level_full", 64'(bus.level), 64'(DEPTH));
    check("stall_req_l_low",  64'(bus.req_l), 64'd0);
    bus.ack_l = 1'b1;
    bus.din   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ack_l = 1'b0;
    check("proto_level_unchanged", 64'(bus.level), 64'(DEPTH));
`ifdef HS_ELASTIC_FIFO_STATS_EN
    check("proto_err_set", 64'(proto_err), 64'd1);
`endif
    p0 = popped;
    repeat (9) cycle(0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("stall_drain_acks", 64'(popped - p0), 64'd4);
    check("stall_drain_level", 64'(bus.level), 64'd0);
`ifdef HS_ELASTIC_FIFO_STATS_EN
    check("stall_max_level", 64'(max_level), 64'(DEPTH));
`endif

    // Empty: requests with no producer, then a single word.
    do_reset();
`ifdef HS_ELASTIC_FIFO_STATS_EN
    check("proto_err_cleared", 64'(proto_err), 64'd0);
    check("max_level_cleared", 64'(max_level), 64'd0);
`endif
    p0 = popped;
    repeat (10) cycle(0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("empty_level", 64'(bus.level), 64'd0);
    check("empty_no_acks", 64'(popped - p0), 64'd0);
    check("empty_req_l_up", 64'(bus.req_l), 64'd1);
`ifdef HS_ELASTIC_FIFO_STATS_EN
    check("empty_stall_cycles", 64'(stall_cycles), 64'd10);
`endif
    bus.ack_l = 1'b1;
    bus.din   = 32'h0000_00A5;
    q.push_back(32'h0000_00A5);
    pushed++;
    @(negedge clk);
    bus.ack_l = 1'b0;
    check("single_no_same_edge_ack", 64'(bus.ack_r), 64'd0);
    check("single_level", 64'(bus.level), 64'd1);
    @(negedge clk);
    check("single_ack", 64'(bus.ack_r), 64'd1);
    check("single_dout", 64'(bus.dout), 64'h0000_00A5);
    repeat (3) cycle(0, 0, 1'b0, 1'b0);

    // Wrap-around with random stalls on both sides.
    next_word = '0; p0 = popped; push0 = pushed;
    for (int i = 0; i < 600 && (popped - p0) < 11; i++) cycle(30, 30, (pushed - push0) < 11, 1'b1);
    check("wrap_words", 64'(popped - p0), 64'd11);
    check("wrap_drained", 64'(q.size()), 64'd0);

    // Reset while three words are stored and a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (int'(bus.level) == 3 && bus.req_l) begin
        found = 1'b1;
        break;
      end
      drive_now(0, 0, 1'b1, 1'b0);
    end
    check("midrst_reached", 64'(found), 64'd1);
    rst       = 1'b1;
    bus.ack_l = 1'b1;
    bus.din   = next_word;
    next_word++;
    bus.req_r = 1'b0;
    q.delete();
    @(negedge clk);
    rst       = 1'b0;
    bus.ack_l = 1'b0;
    check("midrst_level", 64'(bus.level), 64'd0);
    check("midrst_req_l", 64'(bus.req_l), 64'd0);
    check("midrst_ack_r", 64'(bus.ack_r), 64'd0);
    fresh = next_word;
    capture_first = 1'b1;
    p0 = popped;
    for (int i = 0; i < 300 && (popped - p0) < 3; i++) cycle(20, 20, 1'b1, 1'b1);
    for (int i = 0; i < 100 && q.size() != 0; i++) cycle(0, 0, 1'b0, 1'b1);
    check("midrst_first_fresh", 64'(first_pop), 64'(fresh));
    check("midrst_drained", 64'(q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
